ps2_key_tracker: RTL and testbench

- Upstream of the keycode-to-direction decoder: consumes the byte stream from the PS/2 receiver and tracks which non-extended keys are currently held.
- Presents the held-key count plus the two oldest held scan codes, in press order, as keyCount/keyCode1/keyCode2 for the direction decoder.
- Decodes the make/break (F0) protocol, discards extended (E0) and Pause (E1) sequences, and recovers from keyboard resets.

---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_key_table.sv | 72 +++++++
 rtl/ps2_key_tracker.sv | 126 ++++++++++++
 tb/tb_ps2_key_tracker.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 byte constants, tracker FSM state type and a byte-class helper.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    // Bytes remaining in the Pause sequence after its leading E1.
    localparam logic [2:0] PS2_PAUSE_TAIL = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK,
        ST_PAUSE
    } ps2_state_t;

    // Keyboard (re)initialisation or error bytes: every held key is forgotten.
    function automatic logic is_flush_code(input logic [7:0] b);
        return (b == PS2_BAT_OK) || (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

    // Host-protocol responses that never describe a key.
    function automatic logic is_response_code(input logic [7:0] b);
        return (b == PS2_ACK) || (b == PS2_ECHO) || (b == PS2_RESEND);
    endfunction

endpackage

// File: rtl/ps2_key_table.sv
// Held-key table: compact list of scan codes in press order, no duplicates.
// Commands (one per cycle, clear has priority): insert, remove-and-compact, clear.
module ps2_key_table #(
    parameter int MAX_KEYS = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       ins_i,
    input  logic       rem_i,
    input  logic [7:0] code_i,
    output logic [2:0] count_o,
    output logic [7:0] slot0_o,
    output logic [7:0] slot1_o
);

    logic [7:0] table_q [MAX_KEYS];
    logic [7:0] table_d [MAX_KEYS];
    logic [2:0] count_q;
    logic [2:0] count_d;
    logic       hit;
    logic [2:0] hit_idx;

    // Look up the incoming code among valid entries and compute the next table.
    always_comb begin
        table_d = table_q;
        count_d = count_q;
        hit     = 1'b0;
        hit_idx = 3'd0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            if (i < int'(count_q) && table_q[i] == code_i) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
        if (clr_i) begin
            for (int i = 0; i < MAX_KEYS; i++) table_d[i] = 8'h00;
            count_d = 3'd0;
        end else if (ins_i && !hit && int'(count_q) < MAX_KEYS) begin
            for (int i = 0; i < MAX_KEYS; i++) begin
                if (i == int'(count_q)) table_d[i] = code_i;
            end
            count_d = count_q + 3'd1;
        end else if (rem_i && hit) begin
            // Slots above the valid region are already zero, so shifting
            // down also clears the vacated top slot.
            for (int i = 0; i < MAX_KEYS; i++) begin
                if (i >= int'(hit_idx)) begin
                    if (i < MAX_KEYS - 1) table_d[i] = table_q[(i + 1) % MAX_KEYS];
                    else                  table_d[i] = 8'h00;
                end
            end
            count_d = count_q - 3'd1;
        end
    end

    // Table and count registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAX_KEYS; i++) table_q[i] <= 8'h00;
            count_q <= 3'd0;
        end else begin
            table_q <= table_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign slot0_o = table_q[0];
    assign slot1_o = table_q[1];

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 held-key tracker: make/break decode feeding a press-ordered key table.
// Optional stuck-key flush enabled by defining PS2_KEY_TRACKER_TIMEOUT_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a make code or a prefix byte
// ST_BRK     | F0 seen; next byte is the code being released
// ST_EXT     | E0 seen; next byte is an extended code (discarded)
// ST_EXT_BRK | E0 F0 seen; next byte is an extended release (discarded)
// ST_PAUSE   | inside the Pause sequence; pause_q bytes still to swallow
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int MAX_KEYS       = 4,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    output logic [2:0] keyCount,
    output logic [7:0] keyCode1,
    output logic [7:0] keyCode2
);

    ps2_state_t state_q, state_d;
    logic [2:0] pause_q, pause_d;
    logic       tbl_ins, tbl_rem, tbl_clr;
    logic       flush;

`ifdef PS2_KEY_TRACKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_q;

    assign flush = !scan_valid && (idle_q == TW'(TIMEOUT_CYCLES - 1)) && (keyCount != 3'd0);

    // Idle-cycle counter: restarts on any byte or after a flush, saturates when nothing is held.
    always_ff @(posedge Clk) begin
        if (Reset || scan_valid || flush) begin
            idle_q <= '0;
        end else if (idle_q != TW'(TIMEOUT_CYCLES - 1)) begin
            idle_q <= idle_q + 1'b1;
        end
    end
`else
    assign flush = 1'b0;
`endif

    // FSM state and pause counter registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            pause_q <= 3'd0;
        end else begin
            state_q <= state_d;
            pause_q <= pause_d;
        end
    end

    // Next-state decode and table command generation for each accepted byte.
    always_comb begin
        state_d = state_q;
        pause_d = pause_q;
        tbl_ins = 1'b0;
        tbl_rem = 1'b0;
        tbl_clr = 1'b0;
        if (scan_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_code == PS2_BREAK) begin
                        state_d = ST_BRK;
                    end else if (scan_code == PS2_EXT) begin
                        state_d = ST_EXT;
                    end else if (scan_code == PS2_PAUSE) begin
                        state_d = ST_PAUSE;
                        pause_d = PS2_PAUSE_TAIL;
                    end else if (is_flush_code(scan_code)) begin
                        tbl_clr = 1'b1;
                    end else if (!is_response_code(scan_code)) begin
                        tbl_ins = 1'b1;
                    end
                end
                ST_BRK: begin
                    tbl_rem = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_EXT: begin
                    state_d = (scan_code == PS2_BREAK) ? ST_EXT_BRK : ST_IDLE;
                end
                ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                end
                ST_PAUSE: begin
                    pause_d = pause_q - 3'd1;
                    if (pause_q <= 3'd1) begin
                        pause_d = 3'd0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pause_d = 3'd0;
                end
            endcase
        end else if (flush) begin
            state_d = ST_IDLE;
            pause_d = 3'd0;
            tbl_clr = 1'b1;
        end
    end

    ps2_key_table #(
        .MAX_KEYS (MAX_KEYS)
    ) u_table (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .clr_i   (tbl_clr),
        .ins_i   (tbl_ins),
        .rem_i   (tbl_rem),
        .code_i  (scan_code),
        .count_o (keyCount),
        .slot0_o (keyCode1),
        .slot1_o (keyCode2)
    );

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: directed scenarios plus random byte stream
// compared against a queue-based model of held keys.
module tb_ps2_key_tracker;

    localparam int MAX_KEYS = 4;
    localparam int TIMEOUT  = 16;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic [2:0] keyCount;
    logic [7:0] keyCode1;
    logic [7:0] keyCode2;

    int checks   = 0;
    int failures = 0;

    // Reference model: held keys in press order plus protocol context.
    logic [7:0] held[$];
    int         m_skip;
    bit         m_brk, m_ext, m_ext_brk;

    ps2_key_tracker #(
        .MAX_KEYS       (MAX_KEYS),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .keyCount   (keyCount),
        .keyCode1   (keyCode1),
        .keyCode2   (keyCode2)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%02h exp=%02h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0] e1, e2;
        e1 = (held.size() > 0) ? held[0] : 8'h00;
        e2 = (held.size() > 1) ? held[1] : 8'h00;
        check_val({tag, ".count"}, {5'b0, keyCount}, 8'(held.size()));
        check_val({tag, ".k1"}, keyCode1, e1);
        check_val({tag, ".k2"}, keyCode2, e2);
    endtask

    task automatic model_reset();
        held.delete();
        m_skip    = 0;
        m_brk     = 0;
        m_ext     = 0;
        m_ext_brk = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int idx;
        if (m_skip > 0) begin
            m_skip--;
        end else if (m_ext_brk) begin
            m_ext_brk = 0;
        end else if (m_ext) begin
            m_ext = 0;
            if (b == 8'hF0) m_ext_brk = 1;
        end else if (m_brk) begin
            m_brk = 0;
            idx = -1;
            foreach (held[i]) if (held[i] == b) idx = i;
            if (idx >= 0) held.delete(idx);
        end else begin
            case (b)
                8'hF0: m_brk = 1;
                8'hE0: m_ext = 1;
                8'hE1: m_skip = 7;
                8'hAA, 8'h00, 8'hFF: held.delete();
                8'hFA, 8'hEE, 8'hFE: ;
                default: begin
                    idx = -1;
                    foreach (held[i]) if (held[i] == b) idx = i;
                    if (idx < 0 && held.size() < MAX_KEYS) held.push_back(b);
                end
            endcase
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge Clk);
        scan_valid = 1'b1;
        scan_code  = b;
        @(negedge Clk);
        scan_valid = 1'b0;
        model_byte(b);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
    endtask

    function automatic logic [7:0] pick_byte();
        logic [7:0] keys [6] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h15};
        logic [7:0] flushes [3] = '{8'hAA, 8'h00, 8'hFF};
        logic [7:0] resp [3] = '{8'hFA, 8'hEE, 8'hFE};
        int r;
        r = $urandom_range(0, 99);
        if (r < 55)      return keys[$urandom_range(0, 5)];
        else if (r < 68) return 8'hF0;
        else if (r < 76) return 8'hE0;
        else if (r < 79) return 8'hE1;
        else if (r < 82) return flushes[$urandom_range(0, 2)];
        else if (r < 87) return resp[$urandom_range(0, 2)];
        else             return 8'($urandom_range(1, 255));
    endfunction

    initial begin
        Reset      = 1'b1;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        model_reset();
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        check_outputs("reset");

        send(8'h1D);
        check_outputs("make1");
        send(8'h23);
        send(8'h1D);
        check_outputs("repeat");
        send(8'hF0); send(8'h1D);
        check_outputs("break");

        do_reset();
        send(8'h1D); send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B);
        check_outputs("full");
        send(8'hF0); send(8'h1C);
        check_outputs("brk_mid");

        do_reset();
        send(8'h1D);
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        check_outputs("ext");
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        check_outputs("pause");
        send(8'h1C);
        check_outputs("post_pause");
        send(8'hAA);
        check_outputs("bat");

        send(8'h1B);
        @(negedge Clk);
        Reset      = 1'b1;
        scan_valid = 1'b1;
        scan_code  = 8'h23;
        @(negedge Clk);
        Reset      = 1'b0;
        scan_valid = 1'b0;
        model_reset();
        check_outputs("rst_vs_valid");

        send(8'h1D);
        repeat (TIMEOUT) @(negedge Clk);
`ifdef PS2_KEY_TRACKER_TIMEOUT_EN
        model_reset();
`endif
        check_outputs("timeout");
        do_reset();

        for (int n = 0; n < 400; n++) begin
            send(pick_byte());
            check_outputs("rand");
            repeat ($urandom_range(0, 3)) @(negedge Clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
